// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fetch_state_e     : FSM encodings (boot bubble, normal fetch, redirect bubble)
//   DEFAULT_RESET_PC  : default first fetch address after reset
//   PC_STEP           : byte increment between sequential instruction words
//   align_word()      : clears the byte-offset bits of an address
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_REDIR = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_inst_fifo.sv
// Prefetch queue holding {pc, inst} pairs returned from instruction memory.
//   clk, rst_n            : clock, asynchronous active-low clear
//   flush                 : synchronous empty (wins over push and pop)
//   push, push_pc/inst    : write one entry at the tail
//   pop                   : drop the head entry (ignored when empty)
//   count                 : number of valid entries, 0..QDEPTH
//   head_valid/pc/inst    : head entry; pc/inst hold the last shown head when empty
module imem_fetch_ctrl_inst_fifo
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int QW     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_inst,
  input  logic          pop,
  output logic [QW:0]   count,
  output logic          head_valid,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_inst
);

  logic [63:0]   slots [QDEPTH];
  logic [QW-1:0] wr_ptr_q, wr_ptr_d;
  logic [QW-1:0] rd_ptr_q, rd_ptr_d;
  logic [QW:0]   count_q,  count_d;
  logic [63:0]   last_q,   last_d;
  logic          not_empty;
  logic          full;
  logic          do_push;
  logic          do_pop;
  logic [63:0]   head_entry;

  assign not_empty  = (count_q != '0);
  assign full       = (count_q == (QW+1)'(QDEPTH));
  assign do_pop     = pop & not_empty & ~flush;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push    = push & ~flush & (~full | do_pop);
  // When empty the outputs keep showing the most recent head so decode sees no glitch.
  assign head_entry = not_empty ? slots[rd_ptr_q] : last_q;

  assign count      = count_q;
  assign head_valid = not_empty;
  assign head_pc    = head_entry[63:32];
  assign head_inst  = head_entry[31:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (not_empty) last_d = slots[rd_ptr_q];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is never read while its entry is invalid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr_q] <= {push_pc, push_inst};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer between the next-PC mux and a 1-cycle-latency
// instruction memory. Issues word reads, queues returned words with their PCs
// and hands them to decode over a valid/ready handshake.
//   Clk, Clrn             : clock, asynchronous active-low reset
//   MemReq, MemAddr       : memory read strobe and word-aligned byte address
//   MemInst               : word for the request issued in the previous cycle
//   Redirect, RedirectPc  : taken branch/jump; flushes the queue, restarts fetch
//   InstValid, InstReady  : decode handshake, head leaves when both are high
//   InstOut, InstPc       : head instruction word and its byte address
//   Level                 : queued entries, 0..QDEPTH
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 4,
  parameter int          QW       = 2
) (
  input  logic          Clk,
  input  logic          Clrn,
  output logic          MemReq,
  output logic [31:0]   MemAddr,
  input  logic [31:0]   MemInst,
  input  logic          Redirect,
  input  logic [31:0]   RedirectPc,
  output logic          InstValid,
  input  logic          InstReady,
  output logic [31:0]   InstOut,
  output logic [31:0]   InstPc,
  output logic [QW:0]   Level
);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          in_flight_q, in_flight_d;
  logic          issue;
  logic          flush;
  logic          resp_kill;
  logic          push;
  logic          pop;
  logic [QW+1:0] occupancy;
  logic          room;

  // Count the outstanding request so the queue can never be over-filled.
  assign occupancy = {1'b0, Level} + {{(QW+1){1'b0}}, in_flight_q};
  assign room      = (occupancy < (QW+2)'(QDEPTH));

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    in_flight_d = 1'b0;
    issue       = 1'b0;
    flush       = 1'b0;
    resp_kill   = 1'b0;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: begin
        if (!Redirect && room) begin
          issue       = 1'b1;
          req_pc_d    = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + PC_STEP;
          in_flight_d = 1'b1;
        end
      end
      S_REDIR: state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
    // Memory latency is exactly one cycle, so the only response that can be
    // stale is the one arriving in the redirect cycle itself; kill it here.
    if (Redirect && state_q != S_BOOT) begin
      flush      = 1'b1;
      resp_kill  = in_flight_q;
      fetch_pc_d = align_word(RedirectPc);
      state_d    = S_REDIR;
    end
  end

  assign push    = in_flight_q & ~resp_kill;
  assign pop     = InstValid & InstReady;
  assign MemReq  = issue;
  assign MemAddr = fetch_pc_q;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      in_flight_q <= in_flight_d;
    end
  end

  imem_fetch_ctrl_inst_fifo #(
    .QDEPTH (QDEPTH),
    .QW     (QW)
  ) u_fifo (
    .clk        (Clk),
    .rst_n      (Clrn),
    .flush      (flush),
    .push       (push),
    .push_pc    (req_pc_q),
    .push_inst  (MemInst),
    .pop        (pop),
    .count      (Level),
    .head_valid (InstValid),
    .head_pc    (InstPc),
    .head_inst  (InstOut)
  );

endmodule
